score_display_ctrl: RTL
=======================

Name: score_display_ctrl

Overview:
Parametrised 7-segment display controller for the Tetris score, level and line counters. It replaces fixed per-digit nibble drivers with a multi-digit formatter that takes one binary value and performs a sequential binary-to-BCD (double-dabble) conversion, one bit per cycle. It also handles leading-zero blanking, negative-sign placement, overflow indication, a raw-hex mode and optional blinking. It sits between the SoC PIO/game logic and the HEXn pins.

Parameters:
DIGITS, 6, number of 7-segment digits driven (1..8)
VALUE_W, 20, width of the input value in bits (4..32)
SIGNED, 1, 1 = decimal mode treats value as two's complement; 0 = unsigned
BLINK_DIV, 25000000, clk cycles per blink half-period (>=2)

Ports:
clk  in  1  system clock (50 MHz)
reset_n  in  1  asynchronous active-low reset
value  in  VALUE_W  binary value to display
load  in  1  single-cycle request; captures value and mode controls
hex_mode  in  1  1 = show raw hex nibbles; 0 = decimal
blank_lz  in  1  1 = blank leading zeros
blink_en  in  1  1 = blink the whole display
seg  out  8*DIGITS  active-low segments; digit i at seg[8i+7:8i], bit order {dp,g,f,e,d,c,b,a}; digit 0 is rightmost
busy  out  1  conversion in progress
done  out  1  one-cycle pulse when seg has been updated
overflow  out  1  last value did not fit; held until the next update

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: seg all 8'hFF (blank); busy=0; done=0; overflow=0; FSM=IDLE; blink counter=0; blink phase=on.
- dp bit is always 1 (off).
- FSM states: IDLE, SHIFT, FORMAT.
- IDLE: on load=1, capture value, hex_mode, blank_lz; set busy=1 on the next edge.
  - Decimal: SIGNED=1 and value MSB=1 -> neg=1 and magnitude = two's-complement negation, computed at VALUE_W+1 bits so the most negative value is correct. Load shift register; go to SHIFT.
  - Hex mode: go to FORMAT directly; sign is ignored and the value is treated as unsigned.
- SHIFT: exactly VALUE_W cycles.
  - Each cycle: add 3 to every BCD digit >=5, then shift {bcd, mag} left by 1.
  - Any 1 shifted out of the top BCD digit sets a sticky ovf flag.
  - Then go to FORMAT.
- FORMAT: one cycle.
  - Digit source: BCD digits (decimal) or value nibbles (hex; nibbles beyond VALUE_W are 0).
  - Hex overflow: any value bits at or above 4*DIGITS are nonzero.
  - Leading-zero blanking (blank_lz=1): digits above the most significant nonzero digit are 8'hFF; digit 0 is always shown.
  - Negative sign: dash 8'hBF in the digit immediately left of the MSD. If the MSD is digit DIGITS-1, that is overflow.
  - blank_lz=0 with neg=1: dash goes in digit DIGITS-1. Overflow if that digit is nonzero.
  - Overflow: all digits = 8'hBF and overflow=1. Otherwise overflow=0.
  - Register the result into the display buffer; done=1 for one cycle; busy=0; return to IDLE.
- Latency, load sampled at edge 0:
  - Decimal: seg/done update at edge VALUE_W+2.
  - Hex: seg/done update at edge 2.
  - busy is high from edge 1 until the update edge.
- Display buffer: seg holds the previous result throughout a conversion, so no partial digits are ever visible.
- load while busy=1: ignored; no queueing.
- load in the same cycle as the update edge: ignored, because busy is still 1 when it is sampled.
- Segment codes (active-low, dp=1): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- Blink counter: free-runs modulo BLINK_DIV; phase toggles on wrap.
  - blink_en=1 and phase=off: seg outputs 8'hFF on all digits; the buffer itself is untouched.
  - blink_en=0 forces display on immediately; the counter keeps running.
- Reset mid-conversion: everything returns to reset values asynchronously; the conversion is abandoned and no done pulse is produced.

Test Plan:
1. DIGITS=6, VALUE_W=20, decimal, blank_lz=1, load value=1234 -> done at edge 22; seg digits 5..0 = FF,FF,F9,A4,B0,99; overflow=0; busy high for edges 1..21.
2. Signed, value=20'hFFFC8 (-56), blank_lz=1 -> digits = FF,FF,FF,BF,92,82; overflow=0.
3. value=20'h80000 (-524288) -> needs 6 digits plus sign; all digits BF; overflow=1. Then load 0 -> digits FF×5,C0; overflow=0.
4. hex_mode=1, blank_lz=1, value=20'hABCDE -> done at edge 2; digits = FF,88,83,C6,A1,86.
5. Load 1234 (display shows 1234); mid-conversion, load 99 at edge 10 -> ignored; result still 1234. Assert reset_n=0 at edge 5 of the next conversion -> seg all FF, busy=0, no done pulse.
6. BLINK_DIV=4, blink_en=1 with 1234 displayed -> seg alternates between the 1234 pattern and all-FF every 4 cycles; deassert blink_en -> the 1234 pattern shows in the same cycle.

Source files
------------

// File: rtl/score_display_ctrl.sv
// Multi-digit 7-segment formatter: sequential double-dabble binary-to-BCD with
// leading-zero blanking, sign placement, overflow dashes, raw-hex mode and blinking.
module score_display_ctrl #(
   parameter int DIGITS    = 6,
   parameter int VALUE_W   = 20,
   parameter bit SIGNED    = 1'b1,
   parameter int BLINK_DIV = 25000000
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [VALUE_W-1:0]  value,
   input  logic                load,
   input  logic                hex_mode,
   input  logic                blank_lz,
   input  logic                blink_en,
   output logic [8*DIGITS-1:0] seg,
   output logic                busy,
   output logic                done,
   output logic                overflow
);
   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(VALUE_W);
   localparam int BLK_W = $clog2(BLINK_DIV);
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DASH  = 8'hBF;

   typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;

   state_t              state;
   logic                load_q;
   logic [VALUE_W-1:0]  value_q;
   logic                hex_q;
   logic                blz_q;
   logic [VALUE_W:0]    neg_full;
   logic [VALUE_W:0]    mag;
   logic [BCD_W-1:0]    bcd;
   logic [BCD_W-1:0]    bcd_adj;
   logic [CNT_W-1:0]    bit_cnt;
   logic                ovf;
   logic                neg;
   logic                hex;
   logic                blz;
   logic [8*DIGITS-1:0] disp;
   logic [8*DIGITS-1:0] fmt;
   logic                fmt_ovf;
   logic [BCD_W+VALUE_W:0] ext;
   logic                hex_ovf;
   logic [3:0]          digit [DIGITS];
   int                  msd;
   int                  dash_pos;
   logic [BLK_W-1:0]    blink_cnt;
   logic                blink_on;

   function automatic logic [7:0] seg7(input logic [3:0] d);
      case (d)
         4'h0: return 8'hC0;
         4'h1: return 8'hF9;
         4'h2: return 8'hA4;
         4'h3: return 8'hB0;
         4'h4: return 8'h99;
         4'h5: return 8'h92;
         4'h6: return 8'h82;
         4'h7: return 8'hF8;
         4'h8: return 8'h80;
         4'h9: return 8'h90;
         4'hA: return 8'h88;
         4'hB: return 8'h83;
         4'hC: return 8'hC6;
         4'hD: return 8'hA1;
         4'hE: return 8'h86;
         default: return 8'h8E;
      endcase
   endfunction

   // Request is registered first; a load that arrives while busy (or back-to-back) is dropped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         load_q  <= 1'b0;
         value_q <= '0;
         hex_q   <= 1'b0;
         blz_q   <= 1'b0;
      end else begin
         load_q <= load && !busy && !load_q;
         if (load && !busy && !load_q) begin
            value_q <= value;
            hex_q   <= hex_mode;
            blz_q   <= blank_lz;
         end
      end
   end

   // Sign-extend before negating so the most negative input yields its true magnitude.
   assign neg_full = -{value_q[VALUE_W-1], value_q};

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   assign ext     = {{BCD_W{1'b0}}, mag};
   assign hex_ovf = |(ext >> BCD_W);

   always_comb begin
      msd      = 0;
      dash_pos = 0;
      fmt      = {DIGITS{SEG_BLANK}};
      fmt_ovf  = hex ? hex_ovf : ovf;
      for (int i = 0; i < DIGITS; i++) begin
         digit[i] = hex ? ext[4*i +: 4] : bcd[4*i +: 4];
         if (digit[i] != 4'd0)
            msd = i;
      end
      dash_pos = blz ? msd + 1 : DIGITS - 1;
      if (neg) begin
         if (blz && msd == DIGITS - 1)
            fmt_ovf = 1'b1;
         if (!blz && digit[DIGITS-1] != 4'd0)
            fmt_ovf = 1'b1;
      end
      for (int i = 0; i < DIGITS; i++) begin
         if (neg && i == dash_pos)
            fmt[8*i +: 8] = SEG_DASH;
         else if (blz && i > msd)
            fmt[8*i +: 8] = SEG_BLANK;
         else
            fmt[8*i +: 8] = seg7(digit[i]);
      end
      if (fmt_ovf)
         fmt = {DIGITS{SEG_DASH}};
   end

   // disp only changes in FORMAT, so a conversion in flight never shows partial digits.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
         disp     <= {DIGITS{SEG_BLANK}};
         bcd      <= '0;
         mag      <= '0;
         bit_cnt  <= '0;
         ovf      <= 1'b0;
         neg      <= 1'b0;
         hex      <= 1'b0;
         blz      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (load_q) begin
                  busy    <= 1'b1;
                  hex     <= hex_q;
                  blz     <= blz_q;
                  bcd     <= '0;
                  ovf     <= 1'b0;
                  bit_cnt <= '0;
                  if (hex_q) begin
                     neg   <= 1'b0;
                     mag   <= {1'b0, value_q};
                     state <= FORMAT;
                  end else if (SIGNED && value_q[VALUE_W-1]) begin
                     neg   <= 1'b1;
                     mag   <= neg_full;
                     state <= SHIFT;
                  end else begin
                     neg   <= 1'b0;
                     mag   <= {1'b0, value_q};
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               ovf <= ovf | bcd_adj[BCD_W-1];
               bcd <= {bcd_adj[BCD_W-2:0], mag[VALUE_W-1]};
               mag <= {mag[VALUE_W-1:0], 1'b0};
               if (bit_cnt == CNT_W'(VALUE_W - 1))
                  state <= FORMAT;
               else
                  bit_cnt <= bit_cnt + 1'b1;
            end
            FORMAT: begin
               disp     <= fmt;
               overflow <= fmt_ovf;
               done     <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
         blink_cnt <= '0;
         blink_on  <= ~blink_on;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   // Blanking is applied at the output so disabling blink takes effect immediately.
   assign seg = (blink_en && !blink_on) ? {DIGITS{SEG_BLANK}} : disp;

endmodule
